// File: rtl/mpu_host_tx_if.sv
// rtl/mpu_host_tx_if.sv - Avalon-ST byte stream bundle between mpu_host_tx and eth_rx
//
// Purpose: carries one 8-bit Avalon-ST stream (ready latency 0) together with its
//          packet framing sidebands.
// Signals: data[7:0], valid, ready, startofpacket, endofpacket, error[5:0],
//          dsav (high while frame byte 0 or 1 is presented).
// Modports: master = stream source, slave = stream sink.

interface mpu_host_tx_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       startofpacket;
   logic       endofpacket;
   logic [5:0] error;
   logic       dsav;

   modport master (
      output data, valid, startofpacket, endofpacket, error, dsav,
      input  ready
   );

   modport slave (
      input  data, valid, startofpacket, endofpacket, error, dsav,
      output ready
   );
endinterface

// File: rtl/mpu_host_tx.sv
// rtl/mpu_host_tx.sv - MPU command frame transmitter onto an 8-bit Avalon-ST source
//
// Purpose: on start, latches the command header fields and streams a frame:
//          26-byte header, payload_len bytes pulled from pl_*, then zero padding
//          up to MIN_DATA bytes after the length field.
// Ports:   clk, rst (sync, active high)
//          start + header fields (cmd, buffer, buffer_a_idx, buffer_b_idx,
//          dim_x, dim_y, bias, activation, pooling, payload_len)
//          pl_data/pl_valid/pl_ready : upstream payload byte source
//          st (master)               : Avalon-ST output stream
//          busy, done, len_error     : status

module mpu_host_tx #(
   parameter logic [47:0] MAC_DEST    = 48'h0,
   parameter logic [47:0] MAC_SRC     = 48'h0,
   parameter int          MAX_PAYLOAD = 1486,
   parameter int          MIN_DATA    = 46
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [7:0]    cmd,
   input  logic [7:0]    buffer,
   input  logic [7:0]    buffer_a_idx,
   input  logic [7:0]    buffer_b_idx,
   input  logic [7:0]    dim_x,
   input  logic [7:0]    dim_y,
   input  logic [31:0]   bias,
   input  logic [7:0]    activation,
   input  logic [7:0]    pooling,
   input  logic [10:0]   payload_len,
   input  logic [7:0]    pl_data,
   input  logic          pl_valid,
   output logic          pl_ready,
   mpu_host_tx_if.master st,
   output logic          busy,
   output logic          done,
   output logic          len_error
);

   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PAD, LAST} state_t;

   localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD);
   localparam logic [11:0] MIN_TOT = 12'(MIN_DATA);

   state_t      state;
   logic [4:0]  hdr_idx;   // index of the next header byte to load
   logic [10:0] pl_cnt;
   logic [11:0] pad_cnt;

   logic [7:0]  cmd_q, buffer_q, a_idx_q, b_idx_q, dim_x_q, dim_y_q, act_q, pool_q;
   logic [31:0] bias_q;
   logic [10:0] len_q;

   logic [11:0] tot;
   logic [11:0] pad_total;
   logic [15:0] len_field;
   logic [7:0]  hdr_byte;
   logic        ld;

   // Output register may take a new byte when it is empty or being consumed.
   assign ld        = !st.valid || st.ready;
   assign tot       = 12'd12 + {1'b0, len_q};
   assign pad_total = (tot < MIN_TOT) ? (MIN_TOT - tot) : 12'd0;
   assign len_field = {4'd0, tot};
   assign pl_ready  = !rst && (state == PAYLOAD) && ld;
   assign st.error  = 6'd0;

   always_comb begin
      hdr_byte = 8'd0;
      case (hdr_idx)
         5'd0:  hdr_byte = MAC_DEST[47:40];
         5'd1:  hdr_byte = MAC_DEST[39:32];
         5'd2:  hdr_byte = MAC_DEST[31:24];
         5'd3:  hdr_byte = MAC_DEST[23:16];
         5'd4:  hdr_byte = MAC_DEST[15:8];
         5'd5:  hdr_byte = MAC_DEST[7:0];
         5'd6:  hdr_byte = MAC_SRC[47:40];
         5'd7:  hdr_byte = MAC_SRC[39:32];
         5'd8:  hdr_byte = MAC_SRC[31:24];
         5'd9:  hdr_byte = MAC_SRC[23:16];
         5'd10: hdr_byte = MAC_SRC[15:8];
         5'd11: hdr_byte = MAC_SRC[7:0];
         5'd12: hdr_byte = len_field[15:8];
         5'd13: hdr_byte = len_field[7:0];
         5'd14: hdr_byte = cmd_q;
         5'd15: hdr_byte = buffer_q;
         5'd16: hdr_byte = a_idx_q;
         5'd17: hdr_byte = b_idx_q;
         5'd18: hdr_byte = dim_x_q;
         5'd19: hdr_byte = dim_y_q;
         5'd20: hdr_byte = bias_q[31:24];
         5'd21: hdr_byte = bias_q[23:16];
         5'd22: hdr_byte = bias_q[15:8];
         5'd23: hdr_byte = bias_q[7:0];
         5'd24: hdr_byte = act_q;
         5'd25: hdr_byte = pool_q;
         default: hdr_byte = 8'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         hdr_idx          <= 5'd0;
         pl_cnt           <= 11'd0;
         pad_cnt          <= 12'd0;
         st.data          <= 8'd0;
         st.valid         <= 1'b0;
         st.startofpacket <= 1'b0;
         st.endofpacket   <= 1'b0;
         st.dsav          <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         len_error        <= 1'b0;
         cmd_q            <= 8'd0;
         buffer_q         <= 8'd0;
         a_idx_q          <= 8'd0;
         b_idx_q          <= 8'd0;
         dim_x_q          <= 8'd0;
         dim_y_q          <= 8'd0;
         bias_q           <= 32'd0;
         act_q            <= 8'd0;
         pool_q           <= 8'd0;
         len_q            <= 11'd0;
      end else begin
         done      <= 1'b0;
         len_error <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cmd_q    <= cmd;
                  buffer_q <= buffer;
                  a_idx_q  <= buffer_a_idx;
                  b_idx_q  <= buffer_b_idx;
                  dim_x_q  <= dim_x;
                  dim_y_q  <= dim_y;
                  bias_q   <= bias;
                  act_q    <= activation;
                  pool_q   <= pooling;
                  len_q    <= payload_len;
                  if (payload_len > MAX_LEN) begin
                     len_error <= 1'b1;
                  end else begin
                     // Byte 0 depends only on MAC_DEST, so it is loaded directly.
                     state            <= HEADER;
                     busy             <= 1'b1;
                     hdr_idx          <= 5'd1;
                     pl_cnt           <= 11'd0;
                     pad_cnt          <= 12'd0;
                     st.data          <= MAC_DEST[47:40];
                     st.valid         <= 1'b1;
                     st.startofpacket <= 1'b1;
                     st.dsav          <= 1'b1;
                     st.endofpacket   <= 1'b0;
                  end
               end
            end
            HEADER: begin
               if (ld) begin
                  st.data          <= hdr_byte;
                  st.valid         <= 1'b1;
                  st.startofpacket <= 1'b0;
                  st.dsav          <= (hdr_idx == 5'd1);
                  st.endofpacket   <= 1'b0;
                  hdr_idx          <= hdr_idx + 5'd1;
                  if (hdr_idx == 5'd25) begin
                     if (len_q != 11'd0) begin
                        state <= PAYLOAD;
                     end else if (pad_total != 12'd0) begin
                        state <= PAD;
                     end else begin
                        state          <= LAST;
                        st.endofpacket <= 1'b1;
                     end
                  end
               end
            end
            PAYLOAD: begin
               if (ld) begin
                  st.startofpacket <= 1'b0;
                  st.dsav          <= 1'b0;
                  st.endofpacket   <= 1'b0;
                  if (pl_valid) begin
                     st.data  <= pl_data;
                     st.valid <= 1'b1;
                     pl_cnt   <= pl_cnt + 11'd1;
                     if (pl_cnt + 11'd1 == len_q) begin
                        if (pad_total != 12'd0) begin
                           state <= PAD;
                        end else begin
                           state          <= LAST;
                           st.endofpacket <= 1'b1;
                        end
                     end
                  end else begin
                     st.valid <= 1'b0;   // upstream bubble
                  end
               end
            end
            PAD: begin
               if (ld) begin
                  st.data          <= 8'd0;
                  st.valid         <= 1'b1;
                  st.startofpacket <= 1'b0;
                  st.dsav          <= 1'b0;
                  st.endofpacket   <= 1'b0;
                  pad_cnt          <= pad_cnt + 12'd1;
                  if (pad_cnt + 12'd1 == pad_total) begin
                     state          <= LAST;
                     st.endofpacket <= 1'b1;
                  end
               end
            end
            LAST: begin
               // Final byte is on the bus; wait for it to be taken.
               if (st.ready) begin
                  st.data        <= 8'd0;
                  st.valid       <= 1'b0;
                  st.endofpacket <= 1'b0;
                  busy           <= 1'b0;
                  done           <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mpu_host_tx.sv
// tb/tb_mpu_host_tx.sv - scoreboard testbench for mpu_host_tx

module tb_mpu_host_tx;

   localparam logic [47:0] MACD = 48'h0A1B2C3D4E5F;
   localparam logic [47:0] MACS = 48'h112233445566;

   typedef struct packed {
      logic       sop;
      logic       eop;
      logic       dsav;
      logic [7:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  cmd = 8'd0, buffer = 8'd0, buffer_a_idx = 8'd0, buffer_b_idx = 8'd0;
   logic [7:0]  dim_x = 8'd0, dim_y = 8'd0, activation = 8'd0, pooling = 8'd0;
   logic [31:0] bias = 32'd0;
   logic [10:0] payload_len = 11'd0;
   logic [7:0]  pl_data = 8'd0;
   logic        pl_valid = 1'b0;
   logic        pl_ready;
   logic        busy, done, len_error;

   mpu_host_tx_if st_if ();

   mpu_host_tx #(.MAC_DEST(MACD), .MAC_SRC(MACS), .MAX_PAYLOAD(1486), .MIN_DATA(46)) dut (
      .clk(clk), .rst(rst), .start(start), .cmd(cmd), .buffer(buffer),
      .buffer_a_idx(buffer_a_idx), .buffer_b_idx(buffer_b_idx),
      .dim_x(dim_x), .dim_y(dim_y), .bias(bias), .activation(activation),
      .pooling(pooling), .payload_len(payload_len), .pl_data(pl_data),
      .pl_valid(pl_valid), .pl_ready(pl_ready), .st(st_if),
      .busy(busy), .done(done), .len_error(len_error)
   );

   always #5 clk = ~clk;

   exp_t       sb[$];
   int         flen_q[$];
   logic [7:0] plq[$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         byte_cnt = 0;
   int         cyc = 0;
   bit         pl_take = 0;
   bit         gap_en = 0;
   bit         ready_tog = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Builds the expected byte stream from hand-supplied length field and total size.
   task automatic push_exp(input logic [7:0] c, bf, ai, bi, dx, dy, input logic [31:0] bs,
                           input logic [7:0] ac, po, input int len, input logic [15:0] lenf,
                           input int total, input logic [7:0] pseed);
      logic [7:0]  hb[26];
      logic [47:0] md, ms;
      logic [7:0]  b;
      exp_t        e;
      int          idx;
      md = MACD;
      ms = MACS;
      for (int i = 0; i < 6; i++) begin
         hb[i]     = md[47-8*i -: 8];
         hb[6 + i] = ms[47-8*i -: 8];
      end
      hb[12] = lenf[15:8]; hb[13] = lenf[7:0];
      hb[14] = c;  hb[15] = bf; hb[16] = ai; hb[17] = bi; hb[18] = dx; hb[19] = dy;
      hb[20] = bs[31:24]; hb[21] = bs[23:16]; hb[22] = bs[15:8]; hb[23] = bs[7:0];
      hb[24] = ac; hb[25] = po;
      for (idx = 0; idx < total; idx++) begin
         if (idx < 26) b = hb[idx];
         else if (idx < 26 + len) begin
            b = pseed + 8'(idx - 26);
            plq.push_back(b);
         end else b = 8'd0;
         e.sop = (idx == 0); e.dsav = (idx < 2); e.eop = (idx == total - 1); e.d = b;
         sb.push_back(e);
      end
      flen_q.push_back(total);
   endtask

   task automatic launch(input logic [7:0] c, bf, ai, bi, dx, dy, input logic [31:0] bs,
                         input logic [7:0] ac, po, input int len, input logic [15:0] lenf,
                         input int total, input logic [7:0] pseed, input bit hold);
      push_exp(c, bf, ai, bi, dx, dy, bs, ac, po, len, lenf, total, pseed);
      @(posedge clk); #1;
      cmd = c; buffer = bf; buffer_a_idx = ai; buffer_b_idx = bi; dim_x = dx; dim_y = dy;
      bias = bs; activation = ac; pooling = po; payload_len = 11'(len);
      start = 1'b1;
      if (!hold) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < budget);
      chk("done_timeout", 32'(n < budget), 32'd1);
   endtask

   // Stimulus driver for ready and the upstream payload source.
   initial begin
      logic [3:0] pat;
      pat = 4'b1001;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (pl_take && plq.size() > 0) void'(plq.pop_front());
         pl_take = 0;
         st_if.ready = ready_tog ? pat[cyc % 4] : 1'b1;
         pl_valid = (plq.size() > 0) && !(gap_en && (cyc % 5 == 2));
         pl_data  = (plq.size() > 0) ? plq[0] : 8'd0;
      end
   end

   // Monitor: compares every transferred byte with the scoreboard.
   initial begin
      exp_t        e;
      logic [10:0] held;
      bit          stall_prev;
      bit          done_exp;
      stall_prev = 0;
      done_exp   = 0;
      held       = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            byte_cnt   = 0;
            done_exp   = 0;
            stall_prev = 0;
         end else begin
            chk("done", 32'(done), 32'(done_exp));
            done_exp = 0;
            if (stall_prev)
               chk("hold", 32'({st_if.startofpacket, st_if.endofpacket, st_if.dsav, st_if.data}),
                   32'(held));
            if (st_if.valid && st_if.ready) begin
               chk("error", 32'(st_if.error), 32'd0);
               if (sb.size() == 0) begin
                  chk("unexpected_byte", 32'(st_if.data), 32'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  chk($sformatf("byte%0d", byte_cnt),
                      32'({st_if.startofpacket, st_if.endofpacket, st_if.dsav, st_if.data}),
                      32'(e));
               end
               byte_cnt++;
               if (st_if.endofpacket) begin
                  if (flen_q.size() > 0) chk("frame_len", 32'(byte_cnt), 32'(flen_q.pop_front()));
                  byte_cnt = 0;
                  done_exp = 1;
               end
            end
            stall_prev = st_if.valid && !st_if.ready;
            held = {st_if.startofpacket, st_if.endofpacket, st_if.dsav, st_if.data};
            pl_take = pl_valid && pl_ready;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      st_if.ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(st_if.valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_len_error", 32'(len_error), 32'd0);
      chk("rst_pl_ready", 32'(pl_ready), 32'd0);
      chk("rst_flags", 32'({st_if.startofpacket, st_if.endofpacket, st_if.dsav}), 32'd0);

      // Multiply frame, no payload: 34 pad bytes.
      launch(8'h02, 8'h00, 8'h01, 8'h02, 8'h04, 8'h04, 32'hFFFF_FFF7, 8'h01, 8'h00,
             0, 16'h000C, 60, 8'h00, 0);
      wait_done(200);
      chk("busy_after_f1", 32'(busy), 32'd0);

      // Load frame, 3x3 matrix bytes 01..09, 25 pad bytes.
      launch(8'h01, 8'h0A, 8'h00, 8'h00, 8'h03, 8'h03, 32'h0000_0000, 8'h00, 8'h00,
             9, 16'h0015, 60, 8'h01, 0);
      wait_done(200);

      // 100-byte payload with ready stalls and upstream gaps.
      gap_en = 1; ready_tog = 1;
      launch(8'h01, 8'h0B, 8'h05, 8'h06, 8'h0A, 8'h0A, 32'h1234_5678, 8'h02, 8'h03,
             100, 16'h0070, 126, 8'h40, 0);
      wait_done(1000);
      gap_en = 0; ready_tog = 0;

      // Oversized payload is rejected.
      @(posedge clk); #1;
      payload_len = 11'd1487;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("len_error_pulse", 32'(len_error), 32'd1);
      chk("len_error_valid", 32'(st_if.valid), 32'd0);
      chk("len_error_busy", 32'(busy), 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("len_error_quiet", 32'({len_error, st_if.valid, busy}), 32'd0);
      end

      // Maximum payload.
      launch(8'h01, 8'h0A, 8'h07, 8'h08, 8'h20, 8'h20, 32'h0000_0001, 8'h00, 8'h01,
             1486, 16'h05DA, 1512, 8'h00, 0);
      wait_done(3000);

      // Reset part way through the header.
      launch(8'h02, 8'h00, 8'h01, 8'h02, 8'h04, 8'h04, 32'hFFFF_FFF7, 8'h01, 8'h00,
             0, 16'h000C, 60, 8'h00, 0);
      n = 0;
      while (byte_cnt < 10 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reach_byte10", 32'(n < 200), 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      sb.delete();
      flen_q.delete();
      @(negedge clk);
      chk("abort_valid", 32'(st_if.valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_eop", 32'({st_if.valid, st_if.endofpacket, done}), 32'd0);
      end
      launch(8'h01, 8'h0C, 8'h03, 8'h04, 8'h02, 8'h02, 32'h8000_0000, 8'h04, 8'h05,
             4, 16'h0010, 60, 8'hA0, 0);
      wait_done(200);

      // Back-to-back: start held through done.
      push_exp(8'h02, 8'h01, 8'h09, 8'h0A, 8'h02, 8'h01, 32'hDEAD_BEEF, 8'h01, 8'h02,
               2, 16'h000E, 60, 8'h55);
      launch(8'h02, 8'h01, 8'h09, 8'h0A, 8'h02, 8'h01, 32'hDEAD_BEEF, 8'h01, 8'h02,
             2, 16'h000E, 60, 8'h55, 1);
      wait_done(200);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("b2b_sop", 32'({st_if.valid, st_if.startofpacket}), 32'h3);
      wait_done(200);
      repeat (5) @(negedge clk);
      chk("b2b_no_third", 32'({st_if.valid, busy}), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("plq_empty", 32'(plq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
